// File: rtl/serial_sub.sv
// -----------------------------------------------------------------------------
// serial_sub
//
// Bit-serial WIDTH-bit subtractor. One difference/borrow cell is reused for
// every bit position. The borrow between positions is held in a flip-flop.
// The block computes a - b LSB first, one bit per clock, over WIDTH cycles.
// A start/busy/done handshake controls it, and the result is held until the
// next completion.
//
// Parameters
//   WIDTH  operand/result width in bits (2..32)
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous reset, active-high
//   start  in   request a new subtraction (sampled only while idle)
//   a      in   minuend, captured on the accepted start edge
//   b      in   subtrahend, captured on the accepted start edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when d/bo (and ovf) become valid
//   d      out  registered difference a - b mod 2^WIDTH
//   bo     out  registered final borrow (1 when a < b unsigned)
//   ovf    out  signed overflow (only when SERIAL_SUB_OVF_EN is defined)
//
// Optional feature macro: SERIAL_SUB_OVF_EN adds the ovf port together with
// the captured operand MSBs that it needs.
// -----------------------------------------------------------------------------
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Single-bit subtractor cell: returns {borrow_out, difference}.
  function automatic logic [1:0] sub_cell(input logic ai, input logic bi, input logic br);
    logic diff;
    logic bnext;
    diff  = ai ^ bi ^ br;
    bnext = (~ai & bi) | (~(ai ^ bi) & br);
    return {bnext, diff};
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bo_q, bo_d;
  logic [1:0]       cell_s;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  // Next-state and datapath logic for the IDLE/SHIFT/DONE sequencer.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bo_d    = bo_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    cell_s  = sub_cell(a_sr_q[0], b_sr_q[0], br_q);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // Each new difference bit enters at the MSB. After WIDTH shifts the
        // first (LSB) bit has reached position 0.
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        res_d  = {cell_s[0], res_q[WIDTH-1:1]};
        br_d   = cell_s[1];
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Clear instead of incrementing so the counter never wraps.
          cnt_d   = '0;
          d_d     = {cell_s[0], res_q[WIDTH-1:1]};
          bo_d    = cell_s[1];
`ifdef SERIAL_SUB_OVF_EN
          // The final difference bit computed here is the result MSB.
          ovf_d   = (a_msb_q != b_msb_q) & (cell_s[0] != a_msb_q);
`endif
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // busy/done are decoded from the next state so both come out of flops.
    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  // State, datapath and output registers; async reset returns everything to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      d_q     <= '0;
      bo_q    <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      d_q     <= d_d;
      bo_q    <= bo_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bo   = bo_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// -----------------------------------------------------------------------------
// tb_serial_sub
//
// Directed and randomized bench for serial_sub.
// - An 8-bit instance receives directed cases, an abort via reset, a start
//   pulse that arrives while busy, and random operands.
// - A 4-bit instance sweeps all operand pairs back to back with start held.
// Expected results come from plain integer arithmetic on the operands.
// -----------------------------------------------------------------------------
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       busy, done, bo;
  logic [7:0] d;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf;
`endif

  logic       start4 = 1'b0;
  logic [3:0] a4 = 4'h0;
  logic [3:0] b4 = 4'h0;
  logic       busy4, done4, bo4;
  logic [3:0] d4;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .d(d), .bo(bo)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_sub #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .d(d4), .bo(bo4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic exp_ovf8(input logic [7:0] ta, input logic [7:0] tb_v);
    int sa;
    int sb;
    int s;
    sa = int'($signed(ta));
    sb = int'($signed(tb_v));
    s  = sa - sb;
    return (s > 127) || (s < -128);
  endfunction

  // One full operation on the 8-bit instance, with timing and result checks.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v, input bit repulse, input string tag);
    int n;
    int busy_n;
    int extra;
    int ed;
    logic eb;
    ed = (int'(ta) - int'(tb_v) + 256) % 256;
    eb = (ta < tb_v);
    a = ta;
    b = tb_v;
    start = 1'b1;
    tick();
    start = 1'b0;
    // Operands may change freely once accepted.
    a = 8'($urandom);
    b = 8'($urandom);
    n = 0;
    busy_n = 0;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      if (repulse && n == 3) begin
        start = 1'b1;
        a = 8'h10;
        b = 8'h01;
      end else begin
        start = 1'b0;
      end
      tick();
      n++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(n), 32'd8);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_d"}, 32'(d), 32'(ed));
    check({tag, "_bo"}, 32'(bo), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf8(ta, tb_v)));
`endif
    tick();
    check({tag, "_done_width"}, 32'(done), 32'd0);
    check({tag, "_d_hold"}, 32'(d), 32'(ed));
    if (repulse) begin
      extra = 0;
      for (int i = 0; i < 12; i++) begin
        if (done || busy) extra++;
        tick();
      end
      check({tag, "_no_second_op"}, 32'(extra), 32'd0);
      check({tag, "_d_hold_long"}, 32'(d), 32'(ed));
    end
  endtask

  initial begin
    int quiet;
    int accepted;
    int dones;
    int cyc;
    logic prev_busy4;
    logic [3:0] qa[$];
    logic [3:0] qb[$];
    logic [3:0] pa;
    logic [3:0] pb;

    // Reset state
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_d", 32'(d), 32'd0);
    check("rst_bo", 32'(bo), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Directed cases
    do_op(8'h05, 8'h03, 1'b0, "d_5m3");
    do_op(8'h03, 8'h05, 1'b0, "d_3m5");
    do_op(8'hFF, 8'hFF, 1'b0, "d_FFmFF");
    do_op(8'h05, 8'h03, 1'b1, "d_repulse");
    do_op(8'h00, 8'h01, 1'b0, "d_0m1");

    // Abort mid-operation with reset
    a = 8'h05;
    b = 8'h03;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_d", 32'(d), 32'd0);
    check("abort_bo", 32'(bo), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    quiet = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) quiet++;
      tick();
    end
    check("abort_idle_after", 32'(quiet), 32'd0);
    do_op(8'h09, 8'h04, 1'b0, "post_abort");

    // Signed-overflow corners (ovf checked only when the feature exists)
    do_op(8'h80, 8'h01, 1'b0, "o_80m01");
    do_op(8'h7F, 8'hFF, 1'b0, "o_7FmFF");
    do_op(8'h05, 8'h03, 1'b0, "o_05m03");

    // Random operands
    for (int i = 0; i < 20; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'b0, "rand");
    end

    // Exhaustive 4-bit sweep with start held high
    accepted = 0;
    dones = 0;
    cyc = 0;
    prev_busy4 = 1'b0;
    a4 = 4'h0;
    b4 = 4'h0;
    start4 = 1'b1;
    while (dones < 256 && cyc < 2000) begin
      tick();
      cyc++;
      if (busy4 && !prev_busy4) begin
        qa.push_back(a4);
        qb.push_back(b4);
        accepted++;
        if (accepted >= 256) begin
          start4 = 1'b0;
        end else begin
          a4 = 4'(accepted / 16);
          b4 = 4'(accepted % 16);
        end
      end
      if (done4) begin
        dones++;
        if (qa.size() == 0) begin
          check("sweep_spurious_done", 32'd1, 32'd0);
        end else begin
          pa = qa.pop_front();
          pb = qb.pop_front();
          check("sweep_d", 32'(d4), 32'((int'(pa) - int'(pb) + 16) % 16));
          check("sweep_bo", 32'(bo4), 32'(pa < pb));
        end
      end
      prev_busy4 = busy4;
    end
    check("sweep_dones", 32'(dones), 32'd256);
    check("sweep_accepted", 32'(accepted), 32'd256);
    start4 = 1'b0;
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done4) quiet++;
    end
    check("sweep_no_extra_done", 32'(quiet), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
